// File: rtl/snn_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package snn_pkg;

  localparam int V_W = 8;
  localparam int MAX_NEURONS = 8;
  localparam logic [V_W-1:0] THRESH_DEFAULT = 8'd128;
  localparam int LEAK_SHIFT_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/snn_tdm_scheduler_lif_update.sv
// Combinational leaky-integrate-and-fire step: scaled input, leak, saturate, fire/reset.
module lif_update
  import snn_pkg::*;
#(
  parameter logic [V_W-1:0] THRESH     = THRESH_DEFAULT,
  parameter int             LEAK_SHIFT = LEAK_SHIFT_DEFAULT
) (
  input  logic [V_W-1:0] i_v,
  input  logic [7:0]     i_in,
  input  logic [7:0]     i_w,
  output logic [V_W-1:0] o_v_next,
  output logic           o_fire
);

  logic [15:0]    w_prod;
  logic [V_W-1:0] w_p;
  logic [V_W:0]   w_sum;
  logic [V_W-1:0] w_sat;

  always_comb begin
    w_prod = {8'd0, i_in} * {8'd0, i_w};
    w_p    = w_prod[15:8];
    // v - (v >> k) never goes negative, so 9 bits hold the sum without wrap
    w_sum  = {1'b0, i_v} - {1'b0, (i_v >> LEAK_SHIFT)} + {1'b0, w_p};
    w_sat  = w_sum[V_W] ? '1 : w_sum[V_W-1:0];
    o_fire = (w_sat >= THRESH);
    o_v_next = o_fire ? '0 : w_sat;
  end

endmodule

// File: rtl/snn_tdm_scheduler.sv
// N virtual LIF neurons sharing one update datapath, one neuron per cycle per tick.
// Optional feature macro: SNN_REFRACTORY_EN (one-timestep refractory period after a spike).
module snn_tdm_scheduler
  import snn_pkg::*;
#(
  parameter int             N_NEURONS  = 4,
  parameter logic [V_W-1:0] THRESH     = THRESH_DEFAULT,
  parameter int             LEAK_SHIFT = LEAK_SHIFT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic [7:0]           in_i,
  input  logic                 cfg_we_i,
  input  logic [2:0]           cfg_addr_i,
  input  logic [7:0]           cfg_wdata_i,
  output logic                 busy_o,
  output logic [N_NEURONS-1:0] spike_o,
  output logic                 spike_valid_o,
  output logic                 overrun_o
);

  state_t r_state, w_state_nxt;

  logic [2:0]           r_idx;
  logic [7:0]           r_in;
  logic [N_NEURONS-1:0] r_acc;
  logic [N_NEURONS-1:0] r_spike;
  logic                 r_ovr;
  logic [V_W-1:0]       r_v [MAX_NEURONS];
  logic [7:0]           r_w [MAX_NEURONS];

  logic                 w_last;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_cfg_ok;
  logic [N_NEURONS-1:0] w_mask;
  logic [V_W-1:0]       w_v_nxt;
  logic                 w_fire;
  logic [V_W-1:0]       w_v_store;
  logic                 w_fire_eff;
  logic [N_NEURONS-1:0] w_acc_nxt;

  lif_update #(
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_lif (
    .i_v      (r_v[r_idx]),
    .i_in     (r_in),
    .i_w      (r_w[r_idx]),
    .o_v_next (w_v_nxt),
    .o_fire   (w_fire)
  );

`ifdef SNN_REFRACTORY_EN
  logic [N_NEURONS-1:0] r_refr;
  logic                 w_refr_hit;

  always_comb begin
    w_refr_hit = |(r_refr & w_mask);
    w_fire_eff = w_fire & ~w_refr_hit;
    w_v_store  = w_refr_hit ? '0 : w_v_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refr <= '0;
    end else if (r_state == ST_UPDATE) begin
      r_refr <= (r_refr & ~w_mask) | (w_fire_eff ? w_mask : '0);
    end
  end
`else
  always_comb begin
    w_fire_eff = w_fire;
    w_v_store  = w_v_nxt;
  end
`endif

  always_comb begin
    w_last    = (r_idx == 3'(N_NEURONS - 1));
    w_accept  = tick_i && (r_state == ST_IDLE);
    w_drop    = tick_i && (r_state != ST_IDLE);
    w_cfg_ok  = cfg_we_i && ({29'd0, cfg_addr_i} < 32'(N_NEURONS));
    w_mask    = {{(N_NEURONS-1){1'b0}}, 1'b1} << r_idx;
    w_acc_nxt = w_fire_eff ? (r_acc | w_mask) : r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy_o        = (r_state != ST_IDLE);
    spike_valid_o = 1'b0;
    case (r_state)
      ST_IDLE:   if (tick_i) w_state_nxt = ST_UPDATE;
      ST_UPDATE: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        spike_valid_o = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // spike_o is loaded on entry to DONE so it is stable during the valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_in    <= '0;
      r_acc   <= '0;
      r_spike <= '0;
      r_ovr   <= 1'b0;
      for (int unsigned i = 0; i < MAX_NEURONS; i++) begin
        r_v[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      if (w_cfg_ok) r_w[cfg_addr_i] <= cfg_wdata_i;
      if (w_drop) r_ovr <= 1'b1;
      if (w_accept) begin
        r_in  <= in_i;
        r_idx <= '0;
        r_acc <= '0;
      end
      if (r_state == ST_UPDATE) begin
        r_v[r_idx] <= w_v_store;
        r_acc      <= w_acc_nxt;
        if (w_last) begin
          r_idx   <= '0;
          r_spike <= w_acc_nxt;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    spike_o   = r_spike;
    overrun_o = r_ovr;
  end

endmodule

// File: tb/tb_snn_tdm_scheduler.sv
// Randomized self-checking bench for snn_tdm_scheduler against an arithmetic LIF model.
module tb_snn_tdm_scheduler;

  localparam int N = 4;
  localparam int TH = 128;
  localparam int LS = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick_i;
  logic [7:0]   in_i;
  logic         cfg_we_i;
  logic [2:0]   cfg_addr_i;
  logic [7:0]   cfg_wdata_i;
  logic         busy_o;
  logic [N-1:0] spike_o;
  logic         spike_valid_o;
  logic         overrun_o;

  int n_chk = 0;
  int n_bad = 0;

  int mv [8];
  int mw [8];
  bit mrefr [8];
  bit movr;

  snn_tdm_scheduler #(
    .N_NEURONS  (N),
    .THRESH     (8'(TH)),
    .LEAK_SHIFT (LS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .in_i          (in_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .busy_o        (busy_o),
    .spike_o       (spike_o),
    .spike_valid_o (spike_valid_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      mw[i] = 0;
      mrefr[i] = 1'b0;
    end
    movr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick_i = 1'b0;
    cfg_we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we_i = 1'b1;
    cfg_addr_i = a;
    cfg_wdata_i = d;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    if (int'(a) < N) mw[a] = int'(d);
  endtask

  // One timestep. m: edge offset of an optional weight write (-1 none, 0 = with the tick).
  // extra: edge offset at which a second (to-be-dropped) tick is presented (0 none).
  task automatic run_step(input logic [7:0] in, input int m, input logic [2:0] waddr,
                          input logic [7:0] wdata, input int extra);
    logic [N-1:0] e_spk;
    int w, s;
    e_spk = '0;
    for (int j = 0; j < N; j++) begin
      w = (m >= 0 && int'(waddr) == j && m <= j) ? int'(wdata) : mw[j];
`ifdef SNN_REFRACTORY_EN
      if (mrefr[j]) begin
        mrefr[j] = 1'b0;
        mv[j] = 0;
      end else begin
`else
      begin
`endif
        s = mv[j] - mv[j] / (1 << LS) + (int'(in) * w) / 256;
        if (s > 255) s = 255;
        if (s >= TH) begin
          e_spk[j] = 1'b1;
          mv[j] = 0;
          mrefr[j] = 1'b1;
        end else begin
          mv[j] = s;
        end
      end
    end
    if (m >= 0 && int'(waddr) < N) mw[waddr] = int'(wdata);
    if (extra >= 1) movr = 1'b1;

    tick_i = 1'b1;
    in_i = in;
    cfg_addr_i = waddr;
    cfg_wdata_i = wdata;
    cfg_we_i = (m == 0);
    for (int e = 0; e <= N + 1; e++) begin
      @(posedge clk); #1;
      tick_i = (e + 1 == extra);
      cfg_we_i = (m == e + 1);
      chk("valid", 32'(spike_valid_o), 32'(e == N));
      chk("busy", 32'(busy_o), 32'(e <= N));
      if (e == N) chk("spike", 32'(spike_o), 32'(e_spk));
    end
    tick_i = 1'b0;
    cfg_we_i = 1'b0;
    chk("overrun", 32'(overrun_o), 32'(movr));
  endtask

  initial begin
    rst_n = 1'b0;
    tick_i = 1'b0;
    in_i = '0;
    cfg_we_i = 1'b0;
    cfg_addr_i = '0;
    cfg_wdata_i = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(spike_valid_o), 32'd0);
    chk("rst_spike", 32'(spike_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Max product, repeated: fires every time or alternates with refractory
    wr(3'd0, 8'd255);
    repeat (3) run_step(8'd255, -1, 3'd0, 8'd0, 0);

    // Leak/integration sequence 32,60,85,107,126 then fire
    do_reset();
    wr(3'd0, 8'd64);
    repeat (6) run_step(8'd128, -1, 3'd0, 8'd0, 0);

    // Zero weights never fire
    do_reset();
    for (int i = 0; i < 10; i++) run_step(8'($urandom_range(255)), -1, 3'd0, 8'd0, 0);

    // Out-of-range write ignored, then dropped tick sets sticky overrun
    wr(3'd6, 8'd255);
    wr(3'd1, 8'd200);
    run_step(8'd230, -1, 3'd0, 8'd0, 2);
    run_step(8'd230, -1, 3'd0, 8'd0, 0);

    // Reset mid-timestep aborts without a valid pulse
    wr(3'd2, 8'd255);
    tick_i = 1'b1;
    in_i = 8'd255;
    @(posedge clk); #1;
    tick_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_valid", 32'(spike_valid_o), 32'd0);
    chk("abort_ovr", 32'(overrun_o), 32'd0);
    chk("abort_spike", 32'(spike_o), 32'd0);
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_nopulse", 32'(spike_valid_o), 32'd0);
    end
    rst_n = 1'b1;
    run_step(8'd255, -1, 3'd0, 8'd0, 0);

    // Write coincident with tick takes effect in that timestep
    run_step(8'd255, 0, 3'd3, 8'd255, 0);

    // Randomized timesteps with writes landing at random points
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) wr(3'($urandom_range(7)), 8'($urandom_range(255)));
      run_step(8'($urandom_range(255)),
               ($urandom_range(2) == 0) ? -1 : int'($urandom_range(N + 1)),
               3'($urandom_range(7)), 8'($urandom_range(255)),
               ($urandom_range(9) == 0) ? int'($urandom_range(1, N + 1)) : 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
